// File: rtl/shifter_pipe_if.sv
// rtl/shifter_pipe_if.sv - issue/writeback handshake bundle for shifter_pipe; SHIFTER_PIPE_FLAGS_EN adds out_zero/out_carry
interface shifter_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

`ifdef SHIFTER_PIPE_FLAGS_EN
    logic             out_zero;
    logic             out_carry;

    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_carry
    );
    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_carry
    );
`else
    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
`endif
endinterface

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined shift/rotate unit with valid/ready, tag passthrough and flush
// Optional zero/carry result flags when SHIFTER_PIPE_FLAGS_EN is defined.
module shifter_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    shifter_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int LPS = (SHW + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    logic [2:0]        in_op_n;
    logic [STAGES-1:0] st_valid;

    // Unknown opcodes are folded into SRL once, so later stages only see legal ops.
    always_comb begin
        case (bus.in_op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: in_op_n = bus.in_op;
            default:                                in_op_n = OP_SRL;
        endcase
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * LPS;
        localparam int HI = (LO + LPS > SHW) ? SHW : LO + LPS;

        logic             adv;
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [SHW-1:0]   src_shamt;
        logic [2:0]       src_op;
        logic [TAG_W-1:0] src_tag;
        logic [WIDTH-1:0] nxt_data;
        logic             q_valid;
        logic [WIDTH-1:0] q_data;
        logic [TAG_W-1:0] q_tag;
`ifdef SHIFTER_PIPE_FLAGS_EN
        logic             src_carry;
        logic             nxt_carry;
`endif

        // Stage s moves when any stage from s to the output has a hole, or the consumer takes the result.
        assign adv         = ~(&st_valid[STAGES-1:s]) | bus.out_ready;
        assign st_valid[s] = q_valid;

        if (s == 0) begin : g_src
            always_comb begin
                src_valid = bus.in_valid;
                src_op    = in_op_n;
                src_shamt = bus.in_shamt;
                src_tag   = bus.in_tag;
                if (in_op_n == OP_SLL || in_op_n == OP_ROL) src_data = {<<{bus.in_data}};
                else                                        src_data = bus.in_data;
            end
`ifdef SHIFTER_PIPE_FLAGS_EN
            assign src_carry = 1'b0;
`endif
        end else begin : g_src
            assign src_valid = st_valid[s-1];
            assign src_data  = g_stage[s-1].q_data;
            assign src_tag   = g_stage[s-1].q_tag;
            assign src_op    = g_stage[s-1].g_mid.q_op;
            assign src_shamt = g_stage[s-1].g_mid.q_shamt;
`ifdef SHIFTER_PIPE_FLAGS_EN
            assign src_carry = g_stage[s-1].g_mid.q_carry;
`endif
        end

        always_comb begin : layers
            logic [WIDTH-1:0] d;
            int               k;
            d = src_data;
            k = 0;
`ifdef SHIFTER_PIPE_FLAGS_EN
            nxt_carry = src_carry;
`endif
            for (int j = LO; j < HI; j++) begin
                k = 1 << (SHW - 1 - j);
                if ((src_shamt & SHW'(k)) != '0) begin
                    if (src_op == OP_ROL || src_op == OP_ROR) begin
                        d = (d >> k) | (d << (WIDTH - k));
                    end else begin
`ifdef SHIFTER_PIPE_FLAGS_EN
                        nxt_carry = |(d & (WIDTH'(1) << (k - 1)));
`endif
                        if (src_op == OP_SRA) d = $signed(d) >>> k;
                        else                  d = d >> k;
                    end
                end
            end
            if (s == STAGES - 1 && (src_op == OP_SLL || src_op == OP_ROL)) nxt_data = {<<{d}};
            else                                                           nxt_data = d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q_valid <= 1'b0;
                q_data  <= '0;
                q_tag   <= '0;
            end else begin
                if (flush)    q_valid <= 1'b0;
                else if (adv) q_valid <= src_valid;
                if (adv && src_valid) begin
                    q_data <= nxt_data;
                    q_tag  <= src_tag;
                end
            end
        end

        if (s < STAGES - 1) begin : g_mid
            logic [SHW-1:0] q_shamt;
            logic [2:0]     q_op;
`ifdef SHIFTER_PIPE_FLAGS_EN
            logic           q_carry;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_shamt <= '0;
                    q_op    <= OP_SRL;
`ifdef SHIFTER_PIPE_FLAGS_EN
                    q_carry <= 1'b0;
`endif
                end else if (adv && src_valid) begin
                    q_shamt <= src_shamt;
                    q_op    <= src_op;
`ifdef SHIFTER_PIPE_FLAGS_EN
                    q_carry <= nxt_carry;
`endif
                end
            end
        end else begin : g_last
`ifdef SHIFTER_PIPE_FLAGS_EN
            logic q_zero;
            logic q_carry;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_zero  <= 1'b0;
                    q_carry <= 1'b0;
                end else if (adv && src_valid) begin
                    q_zero  <= (nxt_data == '0);
                    q_carry <= nxt_carry;
                end
            end
            assign bus.out_zero  = q_zero;
            assign bus.out_carry = q_carry;
`endif
        end
    end

    assign bus.in_ready  = g_stage[0].adv & ~rst;
    assign bus.out_valid = st_valid[STAGES-1];
    assign bus.out_data  = g_stage[STAGES-1].q_data;
    assign bus.out_tag   = g_stage[STAGES-1].q_tag;
endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - directed self-checking bench for shifter_pipe (WIDTH=32, STAGES=2)
module tb_shifter_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b011;
    localparam logic [2:0] ROL = 3'b100;
    localparam logic [2:0] ROR = 3'b101;
    localparam logic [2:0] BAD = 3'b111;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    shifter_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    shifter_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [31:0] data, input logic [4:0] shamt,
                         input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_tag   = tag;
    endtask

    // One op through an idle pipe with out_ready=1: result must show exactly two edges later.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] data,
                          input logic [4:0] shamt, input logic [4:0] tag, input logic [31:0] exp);
        offer(op, data, shamt, tag);
        #1;
        check({name, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check({name, "_early"}, bus.out_valid, 0);
        tick();
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_data"}, bus.out_data, exp);
        check({name, "_tag"}, bus.out_tag, tag);
    endtask

`ifdef SHIFTER_PIPE_FLAGS_EN
    task automatic check_flags(input string name, input logic carry, input logic zero);
        check({name, "_carry"}, bus.out_carry, carry);
        check({name, "_zero"}, bus.out_zero, zero);
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = SRL;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        offer(SLL, 32'hFFFF_FFFF, 5'd0, 5'd31);
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_tag", bus.out_tag, 0);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("rst", 1'b0, 1'b0);
`endif
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        run_op("sll31", SLL, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("sll31", 1'b0, 1'b0);
`endif
        run_op("sra4", SRA, 32'h8000_0000, 5'd4, 5'd4, 32'hF800_0000);
        run_op("srl4", SRL, 32'h8000_0000, 5'd4, 5'd5, 32'h0800_0000);
        run_op("bad_op", BAD, 32'h8000_0000, 5'd4, 5'd6, 32'h0800_0000);
        run_op("ror8", ROR, 32'h1234_5678, 5'd8, 5'd7, 32'h7812_3456);
        run_op("rol4", ROL, 32'h1234_5678, 5'd4, 5'd8, 32'h2345_6781);
        run_op("ror0", ROR, 32'h1234_5678, 5'd0, 5'd9, 32'h1234_5678);
        run_op("sll0", SLL, 32'h1234_5678, 5'd0, 5'd10, 32'h1234_5678);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("sll0", 1'b0, 1'b0);
`endif
        run_op("sra31", SRA, 32'h8000_0000, 5'd31, 5'd11, 32'hFFFF_FFFF);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("sra31", 1'b0, 1'b0);
`endif
        run_op("rol1", ROL, 32'h8000_0001, 5'd1, 5'd12, 32'h0000_0003);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("rol1", 1'b0, 1'b0);
`endif
        run_op("srl3_1", SRL, 32'h0000_0003, 5'd1, 5'd13, 32'h0000_0001);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("srl3_1", 1'b1, 1'b0);
`endif
        run_op("srl1_1", SRL, 32'h0000_0001, 5'd1, 5'd14, 32'h0000_0000);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("srl1_1", 1'b1, 1'b1);
`endif
        run_op("sll_out", SLL, 32'hC000_0000, 5'd2, 5'd15, 32'h0000_0000);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check_flags("sll_out", 1'b1, 1'b1);
`endif

        // Backpressure: two ops fill the pipe, the third must wait.
        tick();
        bus.out_ready = 1'b0;
        offer(ROR, 32'h1, 5'd4, 5'd1);
        #1;
        check("bp_rdy1", bus.in_ready, 1);
        tick();
        offer(ROR, 32'h2, 5'd4, 5'd2);
        #1;
        check("bp_rdy2", bus.in_ready, 1);
        tick();
        offer(ROR, 32'h3, 5'd4, 5'd3);
        #1;
        check("bp_rdy3", bus.in_ready, 0);
        check("bp_valid", bus.out_valid, 1);
        check("bp_data", bus.out_data, 32'h1000_0000);
        check("bp_tag", bus.out_tag, 1);
        tick();
        check("bp_hold_rdy", bus.in_ready, 0);
        check("bp_hold_data", bus.out_data, 32'h1000_0000);
        check("bp_hold_tag", bus.out_tag, 1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_rdy", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_t2_valid", bus.out_valid, 1);
        check("bp_t2_tag", bus.out_tag, 2);
        check("bp_t2_data", bus.out_data, 32'h2000_0000);
        tick();
        check("bp_t3_valid", bus.out_valid, 1);
        check("bp_t3_tag", bus.out_tag, 3);
        check("bp_t3_data", bus.out_data, 32'h3000_0000);
        tick();
        check("bp_drained", bus.out_valid, 0);

        // Flush with a full, stalled pipe.
        bus.out_ready = 1'b0;
        offer(SRL, 32'h5, 5'd0, 5'd5);
        tick();
        offer(SRL, 32'h6, 5'd0, 5'd6);
        tick();
        offer(SRL, 32'h7, 5'd0, 5'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_full_0", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        tick();
        check("fl_full_1", bus.out_valid, 0);
        tick();
        check("fl_full_2", bus.out_valid, 0);

        // Flush while an input is actually accepted: that input is dropped too.
        offer(SRL, 32'h8, 5'd0, 5'd8);
        tick();
        offer(SRL, 32'h9, 5'd0, 5'd9);
        flush = 1'b1;
        #1;
        check("fl_acc_rdy", bus.in_ready, 1);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_acc_0", bus.out_valid, 0);
        tick();
        check("fl_acc_1", bus.out_valid, 0);
        tick();
        check("fl_acc_2", bus.out_valid, 0);
        run_op("post_flush", SRA, 32'hF000_000F, 5'd4, 5'd10, 32'hFF00_0000);

        // Reset with a full pipe: nothing stale may come out.
        tick();
        bus.out_ready = 1'b0;
        offer(ROR, 32'hB, 5'd4, 5'd11);
        tick();
        offer(ROR, 32'hC, 5'd4, 5'd12);
        tick();
        bus.in_valid = 1'b0;
        check("mid_full", bus.out_data, 32'hB000_0000);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_tag", bus.out_tag, 0);
        tick();
        check("mid_rst_after1", bus.out_valid, 0);
        tick();
        check("mid_rst_after2", bus.out_valid, 0);
        run_op("post_rst", ROL, 32'hA000_0005, 5'd3, 5'd21, 32'h0000_002D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the combinational ALU barrel shifter.
- Performs logical and arithmetic shifts plus rotates on a WIDTH-bit operand.
- Uses log2(WIDTH) mux layers, with the largest shift first, split across STAGES register stages.
- Uses valid/ready handshakes on both sides, a tag passthrough and a flush. It sits between issue and writeback in the execute stage.

Parameters:
- WIDTH, 32, operand width; must be a power of 2, >= 8.
- STAGES, 2, register stages, range 1..log2(WIDTH); latency equals STAGES.
- TAG_W, 5, width of the sideband tag (destination register id).
- Derived localparam SHW = log2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  drop every in-flight op and the input-side op this cycle.
- in_valid  in  1  input op present.
- in_ready  out  1  shifter accepts the op this cycle.
- in_op  in  3  operation: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; other codes are illegal.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount.
- in_tag  in  TAG_W  sideband tag, carried unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset:
  - The clock is clk; reset is rst, synchronous and active-high.
  - While rst=1 at a clock edge, all stage valid bits, out_valid, out_data and out_tag clear to 0.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Datapath:
  - SLL and ROL reverse the bits at the input and at the output around a right-shift core.
  - Layer j (j=0..SHW-1) shifts right by 2^(SHW-1-j) when shamt bit SHW-1-j is set.
  - Fill bit per layer:
    - SRA/SLL/SRL: the fill is the sign bit for SRA, else 0.
    - Rotates: the fill is the bits shifted out.
  - Shift by 0 returns in_data unchanged for every op.
- Pipelining:
  - Layers are grouped ceil(SHW/STAGES) per stage, in order.
  - Each stage register holds the partial result, the remaining shamt bits, op, tag and a valid bit.
  - The last stage register drives out_* directly; there is no combinational path from in_data to out_data.
- Handshake:
  - A transfer occurs when valid and ready are both 1.
  - Stage i advances when its valid is 0 or stage i+1 advances; the last stage advances on out_ready.
  - in_ready = advance of stage 0, so bubbles are collapsed.
  - Throughput is 1 op/cycle when out_ready is held at 1.
  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable.
  - in_ready may depend combinationally on out_ready.
- Flush:
  - flush=1 clears all valid bits at the next edge.
  - An input accepted in the flush cycle is dropped.
  - out_valid is 0 in the cycle after a flush.
  - If rst and flush are both 1, rst wins; the result is the same.
- Illegal op: treated as SRL; no error is signalled.
- Ordering: results leave in acceptance order, and tags are never reordered.

Optional Feature:
- Macro: SHIFTER_PIPE_FLAGS_EN.
- When defined:
  - Adds output out_zero (1 bit), set when out_data==0.
  - Adds output out_carry (1 bit): the last bit shifted out for SLL/SRL/SRA; 0 for rotates and for shamt=0.
  - Both outputs are registered with out_data and follow the same reset/flush/stall rules; their reset value is 0.
- When undefined: these ports and their logic do not exist.

Test Plan:
All cases use WIDTH=32, STAGES=2.
- SLL 0x0000_0001 shamt 31, tag 3 -> out_valid 2 cycles after acceptance, out_data 0x8000_0000, out_tag 3.
- 0x8000_0000 shamt 4 -> SRA gives 0xF800_0000; SRL gives 0x0800_0000.
- 0x1234_5678 -> ROR by 8 gives 0x7812_3456; ROL by 4 gives 0x2345_6781; ROR by 0 gives 0x1234_5678.
- Backpressure:
  - Stimulus: out_ready=0 while 3 back-to-back ops are offered (tags 1,2,3).
  - Required: exactly 2 are accepted; in_ready=0 for the third; out_data/out_tag stay stable while stalled.
  - After raising out_ready, tags appear 1,2,3 on consecutive cycles.
- Flush:
  - Stimulus: 2 ops in flight, then flush asserted together with a new input.
  - Required: no result appears; the next op after the flush completes normally at latency 2.
- Reset mid-operation: rst pulsed for 1 cycle with a full pipe -> out_valid=0 and out_data=0 afterwards; no stale result.
- With SHIFTER_PIPE_FLAGS_EN:
  - SRL 0x0000_0003 by 1 -> out_carry=1, out_zero=0.
  - SLL 0x0000_0001 by... SRL 0x0000_0001 by 1 -> out_data 0, out_zero=1, out_carry=1.
